sbox_pixel_cipher: RTL and testbench

Downstream consumer of the S-box generator in the chaos-based image encryption top. It loads the 256-entry S-box once the generator reports completion, then encrypts a pixel stream. Each pixel is XOR-masked with a chaotic key byte, substituted through the S-box, and chained with the previous cipher byte for diffusion. Output is a valid/ready cipher byte stream with frame framing.

---
 rtl/sbox_pixel_cipher.sv | 101 ++++++++++
 tb/tb_sbox_pixel_cipher.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_pixel_cipher.sv
// S-box substitution cipher with chained diffusion for a framed pixel stream.
// Loads a 256-entry table, then encrypts pixel/key pairs into cipher bytes.
module sbox_pixel_cipher #(
  parameter int         PIXELS = 65536,
  parameter logic [7:0] IV     = 8'h00,
  parameter int         CNT_W  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sbox_we,
  input  logic [7:0] sbox_addr,
  input  logic [7:0] sbox_data,
  input  logic       done_sbox,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_data,
  input  logic [7:0] key_data,
  output logic       c_valid,
  input  logic       c_ready,
  output logic [7:0] c_data,
  output logic       c_last,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS - 1);

  state_t           state;
  logic [7:0]       sbox_q [256];
  logic [7:0]       prev;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             out_fire;
  logic [7:0]       cipher;

  assign pix_ready = (state == RUN) && (!c_valid || c_ready);
  assign accept    = pix_valid && pix_ready;
  assign out_fire  = c_valid && c_ready;
  assign cipher    = sbox_q[pix_data ^ key_data] ^ prev;
  assign busy      = (state != LOAD);

  // Table has no reset; it is only writable while loading.
  always_ff @(posedge clk) begin
    if (state == LOAD && sbox_we)
      sbox_q[sbox_addr] <= sbox_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      c_valid    <= 1'b0;
      c_data     <= 8'h00;
      c_last     <= 1'b0;
      frame_done <= 1'b0;
      prev       <= IV;
      count      <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        LOAD: begin
          if (done_sbox)
            state <= RUN;
        end
        RUN: begin
          if (accept) begin
            c_data  <= cipher;
            prev    <= cipher;
            c_valid <= 1'b1;
            if (count == LAST) begin
              c_last <= 1'b1;
              state  <= FLUSH;
            end else begin
              count <= count + 1'b1;
            end
          end else if (out_fire) begin
            c_valid <= 1'b0;
          end
        end
        FLUSH: begin
          // Chain restarts from IV for the next frame.
          if (out_fire) begin
            c_valid    <= 1'b0;
            c_last     <= 1'b0;
            frame_done <= 1'b1;
            prev       <= IV;
            count      <= '0;
            state      <= RUN;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_pixel_cipher.sv
// Randomized bench for sbox_pixel_cipher against a frame-level cipher model.
// Expected bytes are queued on input accept and popped on output transfer.
module tb_sbox_pixel_cipher;

  localparam int         PIX = 5;
  localparam logic [7:0] IVV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sbox_we = 1'b0;
  logic [7:0] sbox_addr = 8'h00;
  logic [7:0] sbox_data = 8'h00;
  logic       done_sbox = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] pix_data = 8'h00;
  logic [7:0] key_data = 8'h00;
  logic       c_valid;
  logic       c_ready = 1'b0;
  logic [7:0] c_data;
  logic       c_last;
  logic       frame_done;
  logic       busy;

  sbox_pixel_cipher #(
    .PIXELS(PIX),
    .IV    (IVV),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sbox_we   (sbox_we),
    .sbox_addr (sbox_addr),
    .sbox_data (sbox_data),
    .done_sbox (done_sbox),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .key_data  (key_data),
    .c_valid   (c_valid),
    .c_ready   (c_ready),
    .c_data    (c_data),
    .c_last    (c_last),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] mtab [256];
  logic [7:0] mprev = IVV;
  int         mcnt = 0;
  logic [8:0] q [$];
  bit         mon_en = 0;
  bit         fd_exp = 0;
  bit         prev_cv = 0;
  bit         prev_cr = 0;
  logic [7:0] prev_cd = 8'h00;
  int         rdy_mode = 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       c_ready = 1'b1;
      2:       c_ready = 1'b0;
      default: c_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic       lp;
      logic [8:0] e;
      logic [7:0] x;
      lp = 1'b0;
      foreach (q[i]) if (q[i][8]) lp = 1'b1;
      chk("frame_done", frame_done, fd_exp);
      fd_exp = 0;
      chk("c_valid", c_valid, q.size() != 0);
      if (prev_cv && !prev_cr) begin
        chk("hold_valid", c_valid, 1);
        chk("hold_data", c_data, prev_cd);
      end
      if (lp) chk("flush_ready", pix_ready, 0);
      if (c_valid && c_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("c_data", c_data, e[7:0]);
        chk("c_last", c_last, e[8]);
        if (e[8]) fd_exp = 1;
      end
      if (pix_valid && pix_ready) begin
        x = mtab[pix_data ^ key_data] ^ mprev;
        mprev = x;
        mcnt++;
        if (mcnt == PIX) begin
          q.push_back({1'b1, x});
          mprev = IVV;
          mcnt = 0;
        end else begin
          q.push_back({1'b0, x});
        end
      end
      prev_cv = c_valid;
      prev_cr = c_ready;
      prev_cd = c_data;
    end
  end

  task automatic reset_checks();
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_c_last", c_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    mprev = IVV;
    mcnt = 0;
    fd_exp = 0;
    prev_cv = 0;
    mon_en = 1;
  endtask

  task automatic load_table(input int mode);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       v = 8'(i);
        1:       v = ~8'(i);
        default: v = 8'($urandom);
      endcase
      sbox_we   = 1'b1;
      sbox_addr = 8'(i);
      sbox_data = v;
      done_sbox = (i == 255);
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      mtab[i]   = v;
      if (i % 64 == 1) begin
        chk("load_pix_ready", pix_ready, 0);
        chk("load_busy", busy, 0);
      end
    end
    @(posedge clk);
    #1;
    sbox_we   = 1'b0;
    done_sbox = 1'b0;
    pix_valid = 1'b0;
    chk("run_busy", busy, 1);
  endtask

  task automatic send_one(input logic [7:0] p, input logic [7:0] k,
                          input bit noise);
    int cyc;
    pix_valid = 1'b1;
    pix_data  = p;
    key_data  = k;
    if (noise) begin
      sbox_we   = 1'($urandom);
      sbox_addr = 8'($urandom);
      sbox_data = 8'($urandom);
      done_sbox = 1'($urandom);
    end
    cyc = 0;
    @(negedge clk);
    while (!pix_ready && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("accept_timeout", cyc < 200, 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sbox_we   = 1'b0;
    done_sbox = 1'b0;
  endtask

  task automatic send_rand(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_one(8'($urandom), 8'($urandom), noise);
    end
  endtask

  task automatic drain();
    int cyc;
    rdy_mode = 1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1 reset_checks();
    #20;
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;

    // Identity table; 0xFF exercises the write coincident with done_sbox
    load_table(0);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_one(8'h11, 8'h00, 0);
    send_one(8'h22, 8'h00, 0);
    send_one(8'h44, 8'h00, 0);
    send_one(8'h88, 8'h00, 0);
    send_one(8'hFF, 8'h00, 0);
    send_one(8'h01, 8'h00, 0);
    send_one(8'h02, 8'h00, 0);
    drain();

    rdy_mode = 0;
    send_rand(17, 1);
    drain();

    // Backpressure: second pixel must wait while output is stalled
    rdy_mode = 2;
    @(posedge clk);
    #1;
    pix_valid = 1'b1;
    pix_data  = 8'h3C;
    key_data  = 8'h5A;
    @(negedge clk);
    @(posedge clk);
    #1;
    pix_data = 8'hC3;
    key_data = 8'h0F;
    repeat (5) begin
      @(negedge clk);
      chk("bp_pix_ready", pix_ready, 0);
    end
    rdy_mode = 1;
    send_one(8'hC3, 8'h0F, 0);
    drain();

    // Reset part-way through a frame, then reload an inverting table
    send_rand(2, 0);
    do_reset();
    load_table(1);
    rdy_mode = 1;
    send_one(8'h00, 8'h0F, 0);
    rdy_mode = 0;
    send_rand(20, 1);
    drain();

    do_reset();
    load_table(2);
    rdy_mode = 0;
    send_rand(25, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
